// File: rtl/trace_packer.sv
// Packs 2**NTRACE_I trace lanes into TRB_WIDTH-bit words for the trace logger,
// records the trigger position, and in streaming mode fetches words from memory
// and unpacks them back onto the stream lanes.
module trace_packer #(
  parameter int TRB_WIDTH       = 64,
  parameter int TRB_NTRACE_BITS = 3,
  parameter int MAX_LANES       = 8
) (
  input  logic                         CLK_I,
  input  logic                         RST_NI,
  input  logic                         MODE_I,
  input  logic [TRB_NTRACE_BITS-1:0]   NTRACE_I,
  input  logic [MAX_LANES-1:0]         TRACE_I,
  input  logic                         TRG_I,
  input  logic                         TRG_DELAYED_I,
  output logic                         TRG_EVENT_O,
  output logic [$clog2(TRB_WIDTH)-1:0] EVENT_POS_O,
  output logic [TRB_WIDTH-1:0]         DATA_O,
  output logic                         STORE_O,
  input  logic                         STORE_PERM_I,
  output logic                         OVERFLOW_O,
  output logic                         LOAD_REQUEST_O,
  input  logic                         LOAD_GRANT_I,
  input  logic [TRB_WIDTH-1:0]         DATA_I,
  output logic [MAX_LANES-1:0]         STREAM_O,
  output logic                         STREAM_VALID_O
);

  localparam int POS_W   = $clog2(TRB_WIDTH);
  localparam int CNT_W   = POS_W + 1;
  localparam int LOG_MAX = $clog2(MAX_LANES);

  // Configuration captured at word boundaries
  logic                 cfg_mode_reg;
  logic [CNT_W-1:0]     cfg_lanes_reg;

  // Capture side
  logic [POS_W-1:0]     fill_cnt_reg;
  logic [TRB_WIDTH-1:0] cap_reg;

  // Playback side
  logic [TRB_WIDTH-1:0] act_data_reg;
  logic                 act_valid_reg;
  logic [TRB_WIDTH-1:0] nxt_data_reg;
  logic                 nxt_valid_reg;
  logic                 pending_reg;
  logic [POS_W-1:0]     play_idx_reg;

  // Derived combinational signals
  logic [CNT_W-1:0]     in_lanes;
  logic                 at_boundary;
  logic                 eff_mode;
  logic [CNT_W-1:0]     eff_lanes;
  logic [MAX_LANES-1:0] lane_mask;
  logic [MAX_LANES-1:0] sample;
  logic [TRB_WIDTH-1:0] ins_data;
  logic [TRB_WIDTH-1:0] ins_mask;
  logic [TRB_WIDTH-1:0] cap_next;
  logic [CNT_W-1:0]     fill_sum;
  logic                 capture_en;
  logic                 word_done;
  logic [CNT_W-1:0]     play_sum;
  logic                 play_wrap;
  logic [MAX_LANES-1:0] stream_next;
  logic                 grant_take;
  logic                 req_fire;

  // Lane count requested on the inputs: 2**NTRACE_I, clamped to the lane bus width
  always_comb begin
    in_lanes = CNT_W'(MAX_LANES);
    if (int'(NTRACE_I) < LOG_MAX) in_lanes = CNT_W'(1) << NTRACE_I;
  end

  // At a word boundary the live inputs apply immediately, so a word never mixes lane counts
  assign at_boundary = (fill_cnt_reg == '0);
  assign eff_mode    = at_boundary ? MODE_I   : cfg_mode_reg;
  assign eff_lanes   = at_boundary ? in_lanes : cfg_lanes_reg;

  for (genvar gi = 0; gi < MAX_LANES; gi++) begin : g_lane_mask
    assign lane_mask[gi] = (CNT_W'(gi) < eff_lanes);
  end

  assign sample     = TRACE_I & lane_mask;
  assign ins_data   = TRB_WIDTH'(sample) << fill_cnt_reg;
  assign ins_mask   = TRB_WIDTH'(lane_mask) << fill_cnt_reg;
  assign cap_next   = (cap_reg & ~ins_mask) | ins_data;
  assign fill_sum   = {1'b0, fill_cnt_reg} + eff_lanes;
  assign capture_en = !TRG_DELAYED_I;
  assign word_done  = capture_en && (fill_sum == CNT_W'(TRB_WIDTH));

  assign play_sum    = {1'b0, play_idx_reg} + eff_lanes;
  assign play_wrap   = (play_sum == CNT_W'(TRB_WIDTH));
  assign stream_next = MAX_LANES'(act_data_reg >> play_idx_reg) & lane_mask;
  assign grant_take  = LOAD_GRANT_I && pending_reg;
  assign req_fire    = !nxt_valid_reg && !pending_reg;

  // Config latch and sample packing; everything freezes once the post-trigger window closes
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      cfg_mode_reg  <= 1'b0;
      cfg_lanes_reg <= CNT_W'(1);
      fill_cnt_reg  <= '0;
      cap_reg       <= '0;
    end else begin
      if (at_boundary) begin
        cfg_mode_reg  <= MODE_I;
        cfg_lanes_reg <= in_lanes;
      end
      if (capture_en) begin
        cap_reg      <= cap_next;
        fill_cnt_reg <= fill_sum[POS_W-1:0];
      end
    end
  end

  // Hand completed words to the logger, or flag a drop if it cannot take them
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      DATA_O     <= '0;
      STORE_O    <= 1'b0;
      OVERFLOW_O <= 1'b0;
    end else begin
      STORE_O <= 1'b0;
      if (word_done) begin
        DATA_O <= cap_next;
        if (STORE_PERM_I) STORE_O    <= 1'b1;
        else              OVERFLOW_O <= 1'b1;
      end
    end
  end

  // Remember where in the word the first trigger sample landed
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      TRG_EVENT_O <= 1'b0;
      EVENT_POS_O <= '0;
    end else if (TRG_I && !TRG_EVENT_O) begin
      TRG_EVENT_O <= 1'b1;
      EVENT_POS_O <= fill_cnt_reg;
    end
  end

  // Streaming: keep the next-word slot filled from memory and unpack the active word
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      act_data_reg   <= '0;
      act_valid_reg  <= 1'b0;
      nxt_data_reg   <= '0;
      nxt_valid_reg  <= 1'b0;
      pending_reg    <= 1'b0;
      play_idx_reg   <= '0;
      LOAD_REQUEST_O <= 1'b0;
      STREAM_O       <= '0;
      STREAM_VALID_O <= 1'b0;
    end else if (!eff_mode) begin
      // Trace-buffer mode: playback state is flushed and any outstanding request forgotten
      act_valid_reg  <= 1'b0;
      nxt_valid_reg  <= 1'b0;
      pending_reg    <= 1'b0;
      play_idx_reg   <= '0;
      LOAD_REQUEST_O <= 1'b0;
      STREAM_VALID_O <= 1'b0;
    end else begin
      LOAD_REQUEST_O <= req_fire;
      if (act_valid_reg) begin
        STREAM_O       <= stream_next;
        STREAM_VALID_O <= 1'b1;
        if (play_wrap) begin
          // Swap in the next word without a bubble when it is already here
          play_idx_reg  <= '0;
          act_data_reg  <= nxt_data_reg;
          act_valid_reg <= nxt_valid_reg;
          nxt_valid_reg <= 1'b0;
        end else begin
          play_idx_reg <= play_sum[POS_W-1:0];
        end
      end else begin
        // Underrun: valid drops, STREAM_O keeps its last value
        STREAM_VALID_O <= 1'b0;
        if (nxt_valid_reg) begin
          act_data_reg  <= nxt_data_reg;
          act_valid_reg <= 1'b1;
          nxt_valid_reg <= 1'b0;
          play_idx_reg  <= '0;
        end
      end
      // A grant lands after any transfer above so the old next word is never lost
      if (grant_take) begin
        nxt_data_reg  <= DATA_I;
        nxt_valid_reg <= 1'b1;
        pending_reg   <= 1'b0;
      end else if (req_fire) begin
        pending_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_trace_packer.sv
// Self-checking bench for trace_packer: randomized capture, trigger, overflow/freeze,
// streaming playback and reset scenarios against a queue-based reference model.
module tb_trace_packer;

  localparam int W  = 64;
  localparam int NB = 3;
  localparam int ML = 8;
  localparam int PW = 6;

  logic          CLK_I = 1'b0;
  logic          RST_NI = 1'b1;
  logic          MODE_I = 1'b0;
  logic [NB-1:0] NTRACE_I = '0;
  logic [ML-1:0] TRACE_I = '0;
  logic          TRG_I = 1'b0;
  logic          TRG_DELAYED_I = 1'b0;
  logic          STORE_PERM_I = 1'b0;
  logic          LOAD_GRANT_I = 1'b0;
  logic [W-1:0]  DATA_I = '0;
  logic          TRG_EVENT_O;
  logic [PW-1:0] EVENT_POS_O;
  logic [W-1:0]  DATA_O;
  logic          STORE_O;
  logic          OVERFLOW_O;
  logic          LOAD_REQUEST_O;
  logic [ML-1:0] STREAM_O;
  logic          STREAM_VALID_O;

  int checks = 0;
  int failures = 0;

  trace_packer #(.TRB_WIDTH(W), .TRB_NTRACE_BITS(NB), .MAX_LANES(ML)) dut (
    .CLK_I(CLK_I), .RST_NI(RST_NI), .MODE_I(MODE_I), .NTRACE_I(NTRACE_I),
    .TRACE_I(TRACE_I), .TRG_I(TRG_I), .TRG_DELAYED_I(TRG_DELAYED_I),
    .TRG_EVENT_O(TRG_EVENT_O), .EVENT_POS_O(EVENT_POS_O), .DATA_O(DATA_O),
    .STORE_O(STORE_O), .STORE_PERM_I(STORE_PERM_I), .OVERFLOW_O(OVERFLOW_O),
    .LOAD_REQUEST_O(LOAD_REQUEST_O), .LOAD_GRANT_I(LOAD_GRANT_I), .DATA_I(DATA_I),
    .STREAM_O(STREAM_O), .STREAM_VALID_O(STREAM_VALID_O)
  );

  always #5 CLK_I = ~CLK_I;

  // Lane count from the rules: 2**n, clamped to the bus width
  function automatic int lanes_of(int n);
    return (n >= 3) ? ML : (1 << n);
  endfunction

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic do_reset();
    RST_NI = 1'b0; MODE_I = 1'b0; NTRACE_I = '0; TRACE_I = '0; TRG_I = 1'b0;
    TRG_DELAYED_I = 1'b0; STORE_PERM_I = 1'b0; LOAD_GRANT_I = 1'b0; DATA_I = '0;
    repeat (2) tick();
    RST_NI = 1'b1;
  endtask

  task automatic test_reset();
    RST_NI = 1'b1;
    #2 RST_NI = 1'b0;
    #2;
    checks++; if (TRG_EVENT_O !== 1'b0) begin failures++; $display("FAIL reset_trg_event got=%b exp=0", TRG_EVENT_O); end
    checks++; if (EVENT_POS_O !== '0) begin failures++; $display("FAIL reset_event_pos got=%0d exp=0", EVENT_POS_O); end
    checks++; if (DATA_O !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", DATA_O); end
    checks++; if (STORE_O !== 1'b0) begin failures++; $display("FAIL reset_store got=%b exp=0", STORE_O); end
    checks++; if (OVERFLOW_O !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", OVERFLOW_O); end
    checks++; if (LOAD_REQUEST_O !== 1'b0) begin failures++; $display("FAIL reset_load_req got=%b exp=0", LOAD_REQUEST_O); end
    checks++; if (STREAM_O !== '0) begin failures++; $display("FAIL reset_stream got=%h exp=0", STREAM_O); end
    checks++; if (STREAM_VALID_O !== 1'b0) begin failures++; $display("FAIL reset_stream_valid got=%b exp=0", STREAM_VALID_O); end
    repeat (2) tick();
    RST_NI = 1'b1;
    $display("reset: outputs checked");
  endtask

  task automatic test_all_ones();
    logic exp_store;
    do_reset();
    MODE_I = 1'b0; NTRACE_I = 3'd0; STORE_PERM_I = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      TRACE_I = ML'($urandom) | 8'h01;
      tick();
      exp_store = (c == 64);
      checks++;
      if (STORE_O !== exp_store) begin failures++; $display("FAIL ones_store cyc=%0d got=%b exp=%b", c, STORE_O, exp_store); end
      if (exp_store) begin
        checks++;
        if (DATA_O !== {W{1'b1}}) begin failures++; $display("FAIL ones_data got=%h exp=%h", DATA_O, {W{1'b1}}); end
        $display("store lanes=1 data=%h", DATA_O);
      end
    end
  endtask

  task automatic test_const_a5();
    logic exp_store;
    do_reset();
    NTRACE_I = 3'd3; STORE_PERM_I = 1'b1; TRACE_I = 8'hA5;
    for (int c = 1; c <= 32; c++) begin
      tick();
      exp_store = (c % 8 == 0);
      checks++;
      if (STORE_O !== exp_store) begin failures++; $display("FAIL a5_store cyc=%0d got=%b exp=%b", c, STORE_O, exp_store); end
      if (exp_store) begin
        checks++;
        if (DATA_O !== 64'hA5A5_A5A5_A5A5_A5A5) begin failures++; $display("FAIL a5_data got=%h exp=a5a5a5a5a5a5a5a5", DATA_O); end
        $display("store lanes=8 data=%h", DATA_O);
      end
    end
  endtask

  task automatic test_random_capture();
    bit bq[$];
    logic [W-1:0] exp_word;
    logic exp_store, exp_ovf;
    int n, L;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      n = $urandom_range(0, 7);
      L = lanes_of(n);
      NTRACE_I = NB'(n);
      bq.delete();
      exp_ovf = 1'b0;
      exp_word = '0;
      for (int c = 1; c <= 200; c++) begin
        TRACE_I = ML'($urandom);
        STORE_PERM_I = ($urandom_range(0, 3) != 0);
        for (int j = 0; j < L; j++) bq.push_back(TRACE_I[j]);
        exp_store = 1'b0;
        if (bq.size() == W) begin
          for (int j = 0; j < W; j++) exp_word[j] = bq[j];
          bq.delete();
          exp_store = STORE_PERM_I;
          if (!STORE_PERM_I) exp_ovf = 1'b1;
        end
        tick();
        checks++;
        if (STORE_O !== exp_store) begin failures++; $display("FAIL rnd_store n=%0d cyc=%0d got=%b exp=%b", n, c, STORE_O, exp_store); end
        checks++;
        if (OVERFLOW_O !== exp_ovf) begin failures++; $display("FAIL rnd_overflow n=%0d cyc=%0d got=%b exp=%b", n, c, OVERFLOW_O, exp_ovf); end
        if (exp_store) begin
          checks++;
          if (DATA_O !== exp_word) begin failures++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, DATA_O, exp_word); end
          $display("store n=%0d data=%h", n, DATA_O);
        end
      end
    end
  endtask

  task automatic test_trigger();
    int n, L, p, q2;
    logic [PW-1:0] exp_pos;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      if (r == 0) begin n = 2; p = 7; q2 = 12; end
      else begin n = $urandom_range(0, 7); p = $urandom_range(1, 40); q2 = p + $urandom_range(1, 10); end
      L = lanes_of(n);
      exp_pos = PW'(((p - 1) * L) % W);
      NTRACE_I = NB'(n); STORE_PERM_I = 1'b1;
      for (int s = 1; s <= q2 + 3; s++) begin
        TRACE_I = ML'($urandom);
        TRG_I = (s == p) || (s == q2);
        tick();
        checks++;
        if (s < p) begin
          if (TRG_EVENT_O !== 1'b0) begin failures++; $display("FAIL trg_early s=%0d got=%b exp=0", s, TRG_EVENT_O); end
        end else begin
          if (TRG_EVENT_O !== 1'b1 || EVENT_POS_O !== exp_pos) begin
            failures++; $display("FAIL trg_event s=%0d got=%b/%0d exp=1/%0d", s, TRG_EVENT_O, EVENT_POS_O, exp_pos);
          end
        end
      end
      TRG_I = 1'b0;
      $display("trigger n=%0d sample=%0d pos=%0d", n, p, EVENT_POS_O);
    end
  endtask

  task automatic test_overflow_freeze();
    logic exp_store, exp_ovf;
    do_reset();
    NTRACE_I = 3'd3;
    for (int c = 1; c <= 16; c++) begin
      TRACE_I = ML'($urandom);
      STORE_PERM_I = (c > 8);
      tick();
      exp_store = (c == 16);
      exp_ovf = (c >= 8);
      checks++;
      if (STORE_O !== exp_store) begin failures++; $display("FAIL ovf_store cyc=%0d got=%b exp=%b", c, STORE_O, exp_store); end
      checks++;
      if (OVERFLOW_O !== exp_ovf) begin failures++; $display("FAIL ovf_flag cyc=%0d got=%b exp=%b", c, OVERFLOW_O, exp_ovf); end
    end
    TRG_DELAYED_I = 1'b1; STORE_PERM_I = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      TRACE_I = ML'($urandom);
      tick();
      checks++;
      if (STORE_O !== 1'b0 || OVERFLOW_O !== 1'b1) begin
        failures++; $display("FAIL frozen_store cyc=%0d got=%b/%b exp=0/1", c, STORE_O, OVERFLOW_O);
      end
    end
    // Completion coinciding with the freeze is discarded silently
    do_reset();
    NTRACE_I = 3'd3; STORE_PERM_I = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      TRACE_I = ML'($urandom);
      TRG_DELAYED_I = (c >= 8);
      tick();
      checks++;
      if (STORE_O !== 1'b0 || OVERFLOW_O !== 1'b0) begin
        failures++; $display("FAIL freeze_discard cyc=%0d got=%b/%b exp=0/0", c, STORE_O, OVERFLOW_O);
      end
    end
    $display("overflow/freeze scenario done");
  endtask

  task automatic test_stream();
    logic [7:0] sq[$];
    logic [W-1:0] wd;
    logic [7:0] got, m;
    int L, gnt_wait, grants, max_grants, nvalid, first_v, last_v, ncyc;
    bit pend, prev_req;
    for (int r = 0; r < 2; r++) begin
      do_reset();
      MODE_I = 1'b1;
      NTRACE_I = (r == 0) ? 3'd3 : NB'($urandom_range(0, 3));
      L = lanes_of(int'(NTRACE_I));
      m = 8'((1 << L) - 1);
      max_grants = (r == 0) ? 2 : 6;
      ncyc = 60 + max_grants * (W / L) * 2;
      sq.delete();
      gnt_wait = -1; grants = 0; nvalid = 0; first_v = -1; last_v = -1; pend = 0; prev_req = 0;
      for (int c = 0; c < ncyc; c++) begin
        LOAD_GRANT_I = 1'b0;
        DATA_I = {$urandom, $urandom};
        if (gnt_wait == 0) begin
          gnt_wait = -1;
          if (grants < max_grants) begin
            wd = (r == 0) ? 64'h0706050403020100 : DATA_I;
            DATA_I = wd;
            LOAD_GRANT_I = 1'b1;
            for (int k = 0; k < W / L; k++) sq.push_back(8'(wd >> (k * L)) & m);
            grants++;
            pend = 0;
            $display("grant %0d lanes=%0d word=%h", grants, L, wd);
          end
        end else if (gnt_wait > 0) begin
          gnt_wait--;
        end else if (r == 1 && !pend && $urandom_range(0, 7) == 0) begin
          LOAD_GRANT_I = 1'b1;
        end
        tick();
        if (LOAD_REQUEST_O) begin
          checks++;
          if (prev_req || pend) begin failures++; $display("FAIL req_while_pending cyc=%0d got=1 exp=0", c); end
          pend = 1;
          gnt_wait = (r == 0) ? 1 : $urandom_range(0, 3);
        end
        prev_req = LOAD_REQUEST_O;
        if (STREAM_VALID_O) begin
          checks++;
          if (sq.size() == 0) begin
            failures++; $display("FAIL stream_unexpected cyc=%0d got=%h exp=none", c, STREAM_O);
          end else begin
            got = sq.pop_front();
            if (STREAM_O !== got) begin failures++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", c, STREAM_O, got); end
          end
          nvalid++;
          if (first_v < 0) first_v = c;
          last_v = c;
        end
      end
      checks++;
      if (sq.size() != 0) begin failures++; $display("FAIL stream_drain got=%0d left exp=0", sq.size()); end
      if (r == 0) begin
        checks++;
        if (nvalid != 16 || last_v - first_v != 15) begin
          failures++; $display("FAIL stream_continuous got=%0d valid over %0d cycles exp=16/16", nvalid, last_v - first_v + 1);
        end
        checks++;
        if (STREAM_VALID_O !== 1'b0 || STREAM_O !== 8'h07) begin
          failures++; $display("FAIL stream_underrun got=%b/%h exp=0/07", STREAM_VALID_O, STREAM_O);
        end
      end
    end
  endtask

  task automatic test_mode_switch();
    bit req_seen;
    do_reset();
    MODE_I = 1'b1; NTRACE_I = 3'd3; req_seen = 0;
    for (int c = 0; c < 40; c++) begin
      LOAD_GRANT_I = req_seen;
      DATA_I = {$urandom, $urandom};
      tick();
      req_seen = LOAD_REQUEST_O;
    end
    checks++;
    if (STREAM_VALID_O !== 1'b1) begin failures++; $display("FAIL switch_streaming got=%b exp=1", STREAM_VALID_O); end
    MODE_I = 1'b0;
    for (int c = 0; c < 30; c++) begin
      LOAD_GRANT_I = ($urandom_range(0, 1) == 1);
      DATA_I = {$urandom, $urandom};
      tick();
      if (c >= 9) begin
        checks++;
        if (LOAD_REQUEST_O !== 1'b0 || STREAM_VALID_O !== 1'b0) begin
          failures++; $display("FAIL mode0_idle cyc=%0d got=%b/%b exp=0/0", c, LOAD_REQUEST_O, STREAM_VALID_O);
        end
      end
    end
    LOAD_GRANT_I = 1'b0;
    $display("mode switch 1->0 done");
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w;
    logic exp_store;
    do_reset();
    MODE_I = 1'b1; NTRACE_I = 3'd3; STORE_PERM_I = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      TRACE_I = ML'($urandom);
      TRG_I = (c == 2);
      tick();
    end
    TRG_I = 1'b0;
    checks++;
    if (OVERFLOW_O !== 1'b1 || TRG_EVENT_O !== 1'b1) begin
      failures++; $display("FAIL premid_state got=%b/%b exp=1/1", OVERFLOW_O, TRG_EVENT_O);
    end
    #2 RST_NI = 1'b0;
    #1;
    checks++;
    if ({TRG_EVENT_O, EVENT_POS_O, DATA_O, STORE_O, OVERFLOW_O, LOAD_REQUEST_O, STREAM_O, STREAM_VALID_O} !== '0) begin
      failures++; $display("FAIL midreset_outputs got=%b/%0d/%h/%b/%b/%b/%h/%b exp=all0", TRG_EVENT_O, EVENT_POS_O,
                           DATA_O, STORE_O, OVERFLOW_O, LOAD_REQUEST_O, STREAM_O, STREAM_VALID_O);
    end
    tick();
    RST_NI = 1'b1; MODE_I = 1'b0; STORE_PERM_I = 1'b1;
    w = '0;
    for (int c = 0; c < 8; c++) begin
      TRACE_I = ML'($urandom);
      w[c*8 +: 8] = TRACE_I;
      tick();
      exp_store = (c == 7);
      checks++;
      if (STORE_O !== exp_store) begin failures++; $display("FAIL restart_store cyc=%0d got=%b exp=%b", c, STORE_O, exp_store); end
      if (exp_store) begin
        checks++;
        if (DATA_O !== w) begin failures++; $display("FAIL restart_data got=%h exp=%h", DATA_O, w); end
        $display("store after restart data=%h", DATA_O);
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_const_a5();
    test_random_capture();
    test_trigger();
    test_overflow_freeze();
    test_stream();
    test_mode_switch();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
